// File: rtl/dcache_miss_handler_pkg.sv
// ----------------------------------------------------------------------------
// dcache_pkg
//   Shared widths, tag-entry layout and FSM encoding for the data-cache miss
//   handler and its LRU store. The entry stored per way is {valid, dirty, tag}.
// ----------------------------------------------------------------------------
package dcache_pkg;

    localparam int ADDR_W   = 32;               // byte address width
    localparam int INDEX_W  = 4;                // set index width (16 sets)
    localparam int OFFSET_W = 5;                // 32-byte line
    localparam int TAG_W    = 23;               // address tag width
    localparam int LINE_W   = 256;              // line width in bits
    localparam int ENTRY_W  = TAG_W + 2;        // {valid, dirty, tag}
    localparam int NUM_SETS = 1 << INDEX_W;

    // Bit positions inside a stored tag entry
    localparam int VALID_BIT = 24;
    localparam int DIRTY_BIT = 23;

    // Miss FSM state encoding
    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_WB    = 3'd1;
    localparam logic [2:0] ST_FETCH = 3'd2;
    localparam logic [2:0] ST_FILL  = 3'd3;
    localparam logic [2:0] ST_DONE  = 3'd4;

    typedef enum logic [2:0] {
        S_IDLE  = ST_IDLE,
        S_WB    = ST_WB,
        S_FETCH = ST_FETCH,
        S_FILL  = ST_FILL,
        S_DONE  = ST_DONE
    } miss_state_e;

    // Line-aligned byte address of a line given its tag and set
    function automatic logic [ADDR_W-1:0] line_addr(input logic [TAG_W-1:0]   tag,
                                                    input logic [INDEX_W-1:0] index);
        return {tag, index, {OFFSET_W{1'b0}}};
    endfunction

endpackage

// File: rtl/dcache_miss_handler_lru.sv
// ----------------------------------------------------------------------------
// dcache_lru
//   One LRU bit per set for a 2-way cache. The bit names the least-recently
//   used way. A hit on way W or a fill into way W makes the other way LRU.
// Ports
//   clk_i        clock
//   rst_i        asynchronous reset, active-low (clears every bit to 0)
//   rd_index_i   set to look up; rd_lru_o is its current LRU bit
//   hit_we_i     update on hit: lru[hit_index_i] <= ~hit_way_i
//   fill_we_i    update on fill: lru[fill_index_i] <= ~fill_way_i
// ----------------------------------------------------------------------------
module dcache_lru
    import dcache_pkg::*;
(
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [INDEX_W-1:0] rd_index_i,
    output logic               rd_lru_o,
    input  logic               hit_we_i,
    input  logic [INDEX_W-1:0] hit_index_i,
    input  logic               hit_way_i,
    input  logic               fill_we_i,
    input  logic [INDEX_W-1:0] fill_index_i,
    input  logic               fill_way_i
);

    logic [NUM_SETS-1:0] lru_bits;

    generate
        for (genvar gi = 0; gi < NUM_SETS; gi++) begin : g_set
            logic lru_q;
            logic lru_d;

            // Hits and fills never coincide (hits only update while the
            // handler is idle), but fill is given priority for safety.
            always_comb begin
                lru_d = lru_q;
                if (fill_we_i && (fill_index_i == INDEX_W'(gi))) begin
                    lru_d = ~fill_way_i;
                end else if (hit_we_i && (hit_index_i == INDEX_W'(gi))) begin
                    lru_d = ~hit_way_i;
                end
            end

            always_ff @(posedge clk_i or negedge rst_i) begin
                if (!rst_i) begin
                    lru_q <= 1'b0;
                end else begin
                    lru_q <= lru_d;
                end
            end

            assign lru_bits[gi] = lru_q;
        end
    endgenerate

    assign rd_lru_o = lru_bits[rd_index_i];

endmodule

// File: rtl/dcache_miss_handler.sv
// ----------------------------------------------------------------------------
// dcache_miss_handler
//   Miss engine for a 2-way data cache. On a miss it picks a victim way,
//   writes it back if valid and dirty, fetches the missing line, then writes
//   tag+data into the cache SRAM. It also maintains the per-set LRU bits.
// Ports
//   clk_i, rst_i                 clock, asynchronous active-low reset
//   access_i/hit_i/hit_way_i     tag-compare result, drives LRU on hits
//   miss_req_i                   start a miss (sampled only when idle)
//   write_i/index_i/tag_i        the missing access
//   way{0,1}_tag_i/_data_i       stored entries/lines of index_i
//   mem_*                        off-chip line port (request held until ack)
//   fill_*                       one-cycle SRAM write of the fetched line
//   busy_o                       high whenever not idle
//   done_o                       one-cycle pulse at completion
//   Every output is a flop; its next value is derived from the next state.
// ----------------------------------------------------------------------------
module dcache_miss_handler
    import dcache_pkg::*;
(
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               access_i,
    input  logic               hit_i,
    input  logic               hit_way_i,
    input  logic               miss_req_i,
    input  logic               write_i,
    input  logic [INDEX_W-1:0] index_i,
    input  logic [TAG_W-1:0]   tag_i,
    input  logic [ENTRY_W-1:0] way0_tag_i,
    input  logic [ENTRY_W-1:0] way1_tag_i,
    input  logic [LINE_W-1:0]  way0_data_i,
    input  logic [LINE_W-1:0]  way1_data_i,
    output logic               mem_enable_o,
    output logic               mem_write_o,
    output logic [ADDR_W-1:0]  mem_addr_o,
    output logic [LINE_W-1:0]  mem_data_o,
    input  logic [LINE_W-1:0]  mem_data_i,
    input  logic               mem_ack_i,
    output logic               fill_we_o,
    output logic               fill_way_o,
    output logic [ENTRY_W-1:0] fill_tag_o,
    output logic [LINE_W-1:0]  fill_data_o,
    output logic               busy_o,
    output logic               done_o
);

    miss_state_e state_q, state_d;

    // Captured miss context
    logic [INDEX_W-1:0] index_q, index_d;
    logic [TAG_W-1:0]   tag_q, tag_d;
    logic               write_q, write_d;
    logic               victim_way_q, victim_way_d;
    logic [TAG_W-1:0]   victim_tag_q, victim_tag_d;
    logic [LINE_W-1:0]  victim_data_q, victim_data_d;

    // Registered outputs
    logic               mem_enable_q, mem_enable_d;
    logic               mem_write_q, mem_write_d;
    logic [ADDR_W-1:0]  mem_addr_q, mem_addr_d;
    logic [LINE_W-1:0]  mem_data_q, mem_data_d;
    logic               fill_we_q, fill_we_d;
    logic               fill_way_q, fill_way_d;
    logic [ENTRY_W-1:0] fill_tag_q, fill_tag_d;
    logic [LINE_W-1:0]  fill_data_q, fill_data_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    // Victim choice: prefer an invalid way, otherwise evict the LRU way.
    logic               lru_rd;
    logic               vic_way;
    logic [ENTRY_W-1:0] vic_entry;
    logic [LINE_W-1:0]  vic_data;
    logic               hit_update;

    assign vic_way   = !way0_tag_i[VALID_BIT] ? 1'b0 :
                       !way1_tag_i[VALID_BIT] ? 1'b1 : lru_rd;
    assign vic_entry = vic_way ? way1_tag_i : way0_tag_i;
    assign vic_data  = vic_way ? way1_data_i : way0_data_i;

    // A miss in the same cycle as a hit takes precedence; the fill will set
    // the LRU bit for that set anyway.
    assign hit_update = (state_q == S_IDLE) && access_i && hit_i && !miss_req_i;

    dcache_lru u_lru (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .rd_index_i   (index_i),
        .rd_lru_o     (lru_rd),
        .hit_we_i     (hit_update),
        .hit_index_i  (index_i),
        .hit_way_i    (hit_way_i),
        .fill_we_i    (fill_we_q),
        .fill_index_i (index_q),
        .fill_way_i   (victim_way_q)
    );

    always_comb begin
        state_d       = state_q;
        index_d       = index_q;
        tag_d         = tag_q;
        write_d       = write_q;
        victim_way_d  = victim_way_q;
        victim_tag_d  = victim_tag_q;
        victim_data_d = victim_data_q;

        case (state_q)
            S_IDLE: begin
                if (miss_req_i) begin
                    index_d       = index_i;
                    tag_d         = tag_i;
                    write_d       = write_i;
                    victim_way_d  = vic_way;
                    victim_tag_d  = vic_entry[TAG_W-1:0];
                    victim_data_d = vic_data;
                    state_d = (vic_entry[VALID_BIT] && vic_entry[DIRTY_BIT]) ? S_WB : S_FETCH;
                end
            end
            S_WB:    if (mem_ack_i) state_d = S_FETCH;
            S_FETCH: if (mem_ack_i) state_d = S_FILL;
            S_FILL:  state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // Outputs follow the state being entered so they appear with it.
        mem_enable_d = (state_d == S_WB) || (state_d == S_FETCH);
        mem_write_d  = (state_d == S_WB);
        mem_addr_d   = '0;
        if (state_d == S_WB) begin
            mem_addr_d = line_addr(victim_tag_d, index_d);
        end else if (state_d == S_FETCH) begin
            mem_addr_d = line_addr(tag_d, index_d);
        end
        mem_data_d  = (state_d == S_WB) ? victim_data_d : '0;

        fill_we_d   = (state_d == S_FILL);
        fill_way_d  = fill_we_d & victim_way_d;
        fill_tag_d  = fill_we_d ? {1'b1, write_d, tag_d} : '0;
        // FILL is entered only from FETCH on ack, so the read data goes
        // straight into the fill register.
        fill_data_d = ((state_q == S_FETCH) && mem_ack_i) ? mem_data_i : '0;

        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q       <= S_IDLE;
            index_q       <= '0;
            tag_q         <= '0;
            write_q       <= 1'b0;
            victim_way_q  <= 1'b0;
            victim_tag_q  <= '0;
            victim_data_q <= '0;
            mem_enable_q  <= 1'b0;
            mem_write_q   <= 1'b0;
            mem_addr_q    <= '0;
            mem_data_q    <= '0;
            fill_we_q     <= 1'b0;
            fill_way_q    <= 1'b0;
            fill_tag_q    <= '0;
            fill_data_q   <= '0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            index_q       <= index_d;
            tag_q         <= tag_d;
            write_q       <= write_d;
            victim_way_q  <= victim_way_d;
            victim_tag_q  <= victim_tag_d;
            victim_data_q <= victim_data_d;
            mem_enable_q  <= mem_enable_d;
            mem_write_q   <= mem_write_d;
            mem_addr_q    <= mem_addr_d;
            mem_data_q    <= mem_data_d;
            fill_we_q     <= fill_we_d;
            fill_way_q    <= fill_way_d;
            fill_tag_q    <= fill_tag_d;
            fill_data_q   <= fill_data_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
        end
    end

    assign mem_enable_o = mem_enable_q;
    assign mem_write_o  = mem_write_q;
    assign mem_addr_o   = mem_addr_q;
    assign mem_data_o   = mem_data_q;
    assign fill_we_o    = fill_we_q;
    assign fill_way_o   = fill_way_q;
    assign fill_tag_o   = fill_tag_q;
    assign fill_data_o  = fill_data_q;
    assign busy_o       = busy_q;
    assign done_o       = done_q;

endmodule

// File: tb/tb_dcache_miss_handler.sv
// ----------------------------------------------------------------------------
// tb_dcache_miss_handler
//   Directed misses and hits. Each stimulus pushes its expected memory
//   requests, fill and completion cycle into queues; a monitor pops and
//   compares whenever the DUT presents them. A responder acks memory requests
//   after a per-test delay and returns address-derived line data.
// ----------------------------------------------------------------------------
module tb_dcache_miss_handler;
    import dcache_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic               rst_i;
    logic               access_i, hit_i, hit_way_i, miss_req_i, write_i;
    logic [INDEX_W-1:0] index_i;
    logic [TAG_W-1:0]   tag_i;
    logic [ENTRY_W-1:0] way0_tag_i, way1_tag_i;
    logic [LINE_W-1:0]  way0_data_i, way1_data_i;
    logic               mem_enable_o, mem_write_o;
    logic [ADDR_W-1:0]  mem_addr_o;
    logic [LINE_W-1:0]  mem_data_o, mem_data_i;
    logic               mem_ack_i, resp_ack, spur_ack;
    logic               fill_we_o, fill_way_o;
    logic [ENTRY_W-1:0] fill_tag_o;
    logic [LINE_W-1:0]  fill_data_o;
    logic               busy_o, done_o;

    assign mem_ack_i = resp_ack | spur_ack;

    dcache_miss_handler dut (
        .clk_i(clk), .rst_i(rst_i),
        .access_i(access_i), .hit_i(hit_i), .hit_way_i(hit_way_i),
        .miss_req_i(miss_req_i), .write_i(write_i),
        .index_i(index_i), .tag_i(tag_i),
        .way0_tag_i(way0_tag_i), .way1_tag_i(way1_tag_i),
        .way0_data_i(way0_data_i), .way1_data_i(way1_data_i),
        .mem_enable_o(mem_enable_o), .mem_write_o(mem_write_o),
        .mem_addr_o(mem_addr_o), .mem_data_o(mem_data_o),
        .mem_data_i(mem_data_i), .mem_ack_i(mem_ack_i),
        .fill_we_o(fill_we_o), .fill_way_o(fill_way_o),
        .fill_tag_o(fill_tag_o), .fill_data_o(fill_data_o),
        .busy_o(busy_o), .done_o(done_o)
    );

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int rd_delay = 0;
    int wb_delay = 0;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [255:0] data;
    } mem_exp_t;

    typedef struct {
        logic         way;
        logic [24:0]  tag;
        logic [255:0] data;
    } fill_exp_t;

    mem_exp_t  mem_q[$];
    fill_exp_t fill_q[$];
    int        done_q[$];

    function automatic logic [LINE_W-1:0] mem_line(input logic [ADDR_W-1:0] a);
        return {8{a ^ 32'h5A5A_C3C3}};
    endfunction

    function automatic logic [LINE_W-1:0] way_line(input logic way, input logic [INDEX_W-1:0] idx);
        logic [31:0] w;
        w = (way ? 32'hB1B1_0000 : 32'hA0A0_0000) | {28'h0, idx};
        return {8{w}};
    endfunction

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- memory responder ----------------
    initial begin
        int  rcnt;
        logic rprev;
        rcnt = 0;
        resp_ack = 1'b0;
        mem_data_i = '0;
        forever begin
            @(negedge clk);
            if (!rst_i) begin
                resp_ack = 1'b0;
                rcnt = 0;
            end else begin
                rprev = resp_ack;
                resp_ack = 1'b0;
                if (rprev) rcnt = 0;
                if (mem_enable_o) begin
                    if (rcnt >= (mem_write_o ? wb_delay : rd_delay)) resp_ack = 1'b1;
                    else rcnt++;
                end else begin
                    rcnt = 0;
                end
                mem_data_i = mem_line(mem_addr_o);
            end
        end
    end

    // ---------------- monitor / scoreboard ----------------
    initial begin
        logic      en_prev, wr_prev, have_cur;
        mem_exp_t  cur;
        fill_exp_t f;
        int        dexp;
        en_prev = 1'b0; wr_prev = 1'b0; have_cur = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_i) begin
                en_prev = 1'b0; wr_prev = 1'b0; have_cur = 1'b0;
            end else begin
                if (mem_enable_o) begin
                    if (!en_prev || (mem_write_o != wr_prev)) begin
                        if (mem_q.size() == 0) begin
                            checks++; failures++; have_cur = 1'b0;
                            $display("FAIL mem_unexpected: got wr=%0d addr=%h, expected no request",
                                     mem_write_o, mem_addr_o);
                        end else begin
                            cur = mem_q.pop_front();
                            have_cur = 1'b1;
                        end
                    end
                    if (have_cur) begin
                        chk("mem_write", mem_write_o, cur.wr);
                        chk("mem_addr", mem_addr_o, cur.addr);
                        if (cur.wr) chk("mem_wdata", mem_data_o, cur.data);
                    end
                    $display("cyc %0d mem req wr=%0d addr=%h", cyc, mem_write_o, mem_addr_o);
                end else begin
                    have_cur = 1'b0;
                end
                en_prev = mem_enable_o;
                wr_prev = mem_write_o;

                if (fill_we_o) begin
                    $display("cyc %0d fill way=%0d tag=%h", cyc, fill_way_o, fill_tag_o);
                    if (fill_q.size() == 0) begin
                        checks++; failures++;
                        $display("FAIL fill_unexpected: got way=%0d tag=%h, expected no fill",
                                 fill_way_o, fill_tag_o);
                    end else begin
                        f = fill_q.pop_front();
                        chk("fill_way", fill_way_o, f.way);
                        chk("fill_tag", fill_tag_o, f.tag);
                        chk("fill_data", fill_data_o, f.data);
                    end
                end

                if (done_o) begin
                    $display("cyc %0d done", cyc);
                    chk("done_busy", busy_o, 1'b1);
                    if (done_q.size() == 0) begin
                        checks++; failures++;
                        $display("FAIL done_unexpected: got done at cycle %0d, expected none", cyc);
                    end else begin
                        dexp = done_q.pop_front();
                        chk("done_cycle", cyc, dexp);
                    end
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic wait_idle(input int max_cycles);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (busy_o && (n < max_cycles));
        chk("idle_timeout", busy_o, 1'b0);
        @(posedge clk);
        #1;
    endtask

    task automatic hit(input logic [3:0] idx, input logic way);
        access_i = 1'b1; hit_i = 1'b1; hit_way_i = way; index_i = idx;
        @(posedge clk);
        #1;
        access_i = 1'b0; hit_i = 1'b0;
        $display("cyc %0d hit idx=%0d way=%0d", cyc, idx, way);
    endtask

    // Issue one miss with hand-chosen expected victim and write-back flag.
    // With poke set, a second miss_req is pulsed while the first is busy.
    task automatic do_miss(input logic [3:0] idx, input logic [22:0] tag, input logic wr,
                           input logic [24:0] w0, input logic [24:0] w1,
                           input logic exp_way, input logic exp_wb,
                           input int rdd, input int wbd, input logic poke);
        logic [24:0] vic;
        logic [31:0] faddr;
        mem_exp_t    m;
        fill_exp_t   f;
        rd_delay = rdd;
        wb_delay = wbd;
        vic = exp_way ? w1 : w0;
        if (exp_wb) begin
            m.wr = 1'b1;
            m.addr = {vic[22:0], idx, 5'b0};
            m.data = way_line(exp_way, idx);
            mem_q.push_back(m);
        end
        faddr = {tag, idx, 5'b0};
        m.wr = 1'b0; m.addr = faddr; m.data = '0;
        mem_q.push_back(m);
        f.way = exp_way; f.tag = {1'b1, wr, tag}; f.data = mem_line(faddr);
        fill_q.push_back(f);
        done_q.push_back(cyc + (exp_wb ? wbd + 1 : 0) + rdd + 3);

        index_i = idx; tag_i = tag; write_i = wr;
        way0_tag_i = w0; way1_tag_i = w1;
        way0_data_i = way_line(1'b0, idx); way1_data_i = way_line(1'b1, idx);
        miss_req_i = 1'b1;
        $display("cyc %0d miss idx=%0d tag=%h wr=%0d", cyc, idx, tag, wr);
        @(posedge clk);
        #1;
        miss_req_i = 1'b0;
        if (poke) begin
            @(posedge clk);
            #1;
            index_i = 4'd1; tag_i = 23'h7FFFF; miss_req_i = 1'b1;
            @(posedge clk);
            #1;
            miss_req_i = 1'b0;
        end
        wait_idle(200);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        mem_exp_t m;
        rst_i = 1'b0; access_i = 1'b0; hit_i = 1'b0; hit_way_i = 1'b0;
        miss_req_i = 1'b0; write_i = 1'b0; index_i = '0; tag_i = '0;
        way0_tag_i = '0; way1_tag_i = '0; way0_data_i = '0; way1_data_i = '0;
        spur_ack = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", busy_o, 1'b0);
        chk("rst_mem_en", mem_enable_o, 1'b0);
        chk("rst_mem_addr", mem_addr_o, '0);
        chk("rst_fill_we", fill_we_o, 1'b0);
        chk("rst_done", done_o, 1'b0);
        rst_i = 1'b1;
        @(posedge clk);
        #1;

        // Both ways invalid, clean fetch, ack immediately
        do_miss(4'd3, 23'h12345, 1'b0, 25'h0, 25'h0, 1'b0, 1'b0, 0, 0, 1'b0);

        // lru[5]=1 via hit on way0; way1 dirty -> write-back then fetch (store)
        hit(4'd5, 1'b0);
        do_miss(4'd5, 23'h0ABCD, 1'b1, {2'b10, 23'h00111}, {2'b11, 23'h00222},
                1'b1, 1'b1, 20, 2, 1'b0);
        // Fill into way1 left lru[5]=0 -> clean victim way0
        do_miss(4'd5, 23'h0CCCC, 1'b0, {2'b10, 23'h00111}, {2'b10, 23'h00222},
                1'b0, 1'b0, 3, 0, 1'b0);

        // Hits way0 then way1 on set 7 -> LRU is way0
        hit(4'd7, 1'b0);
        hit(4'd7, 1'b1);
        do_miss(4'd7, 23'h07777, 1'b0, {2'b10, 23'h00333}, {2'b10, 23'h00444},
                1'b0, 1'b0, 1, 0, 1'b0);

        // Hits way1 then way0 on set 8 -> LRU is way1 (dirty, zero-delay WB ack)
        hit(4'd8, 1'b1);
        hit(4'd8, 1'b0);
        do_miss(4'd8, 23'h08888, 1'b1, {2'b11, 23'h00555}, {2'b11, 23'h00666},
                1'b1, 1'b1, 4, 0, 1'b0);

        // Way1 invalid is preferred over a dirty way0 even with lru=0
        do_miss(4'd10, 23'h0AAAA, 1'b1, {2'b11, 23'h00777}, 25'h0,
                1'b1, 1'b0, 2, 0, 1'b0);

        // Reset during write-back (lru[5]=1 -> dirty way1 victim)
        rd_delay = 60; wb_delay = 60;
        m.wr = 1'b1; m.addr = {23'h00222, 4'd5, 5'b0}; m.data = way_line(1'b1, 4'd5);
        mem_q.push_back(m);
        index_i = 4'd5; tag_i = 23'h0DDDD; write_i = 1'b0;
        way0_tag_i = {2'b10, 23'h00111}; way1_tag_i = {2'b11, 23'h00222};
        way0_data_i = way_line(1'b0, 4'd5); way1_data_i = way_line(1'b1, 4'd5);
        miss_req_i = 1'b1;
        @(posedge clk);
        #1;
        miss_req_i = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("abort_in_wb", mem_write_o, 1'b1);
        rst_i = 1'b0;
        #1;
        chk("abort_busy", busy_o, 1'b0);
        chk("abort_mem_en", mem_enable_o, 1'b0);
        chk("abort_mem_wr", mem_write_o, 1'b0);
        chk("abort_mem_addr", mem_addr_o, '0);
        chk("abort_mem_data", mem_data_o, '0);
        $display("cyc %0d reset during write-back", cyc);
        repeat (2) @(posedge clk);
        #1;
        rst_i = 1'b1;
        @(posedge clk);
        #1;
        // LRU cleared by reset -> both-clean set 5 evicts way0
        do_miss(4'd5, 23'h0EEEE, 1'b0, {2'b10, 23'h00111}, {2'b10, 23'h00222},
                1'b0, 1'b0, 2, 0, 1'b0);

        // miss_req pulsed while busy must be ignored
        do_miss(4'd12, 23'h0F0F0, 1'b1, 25'h0, 25'h0, 1'b0, 1'b0, 5, 0, 1'b1);

        // Spurious ack while idle must not start anything
        spur_ack = 1'b1;
        @(posedge clk);
        #1;
        spur_ack = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("spurious_ack_busy", busy_o, 1'b0);
        chk("spurious_ack_mem_en", mem_enable_o, 1'b0);

        chk("mem_q_left", mem_q.size(), 0);
        chk("fill_q_left", fill_q.size(), 0);
        chk("done_q_left", done_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no completion, expected finish before timeout");
        $fatal(1, "timeout");
    end

endmodule
